multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Multi-cycle successor to the single-cycle control unit: a Moore state machine that sequences each RV32I instruction over 2–5 cycles through a shared ALU and a unified instruction/data memory. Adds variable-latency memory stalls, optional `jal` and `bne`, a no-op opcode and a sticky illegal-instruction flag. Sits between the instruction register and the multi-cycle datapath, and reuses the existing `alu_ctrl` for ALU decoding.

## Interface
- `WAIT_MEM`, 1: when 1, FETCH/MEMREAD/MEMWRITE hold until `mem_ready`; when 0, `mem_ready` is ignored and treated as 1.
- `HAS_JAL`, 1: when 0, opcode 1101111 is illegal.
- `HAS_BNE`, 1: when 0, branch funct3 001 is illegal.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 7: IR[6:0].
- `funct3` in 3: IR[14:12].
- `funct7` in 7: IR[31:25].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory access completes this cycle.
- `pc_write` out 1: PC register enable.
- `adr_src` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `mem_write` out 1: memory write strobe.
- `ir_write` out 1: IR and OldPC enable.
- `reg_write` out 1: register file write enable.
- `result_src` out 2: result mux select. 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `alu_src_a` out 2: ALU A select. 00 = PC, 01 = OldPC, 10 = A.
- `alu_src_b` out 2: ALU B select. 00 = WriteData, 01 = ImmExt, 10 = constant 4.
- `imm_src` out 2: immediate format. 00 = I, 01 = S, 10 = B, 11 = J.
- `alu_control` out 4: from `alu_ctrl`.
- `illegal` out 1: sticky illegal-instruction flag.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, ILLEGAL.
- Outputs not listed for a state are 0. `alu_op` defaults to 00.
- FETCH: `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `result_src`=10.
  - When `mem_ready`: `ir_write`=`pc_write`=1, next DECODE. Otherwise stay.
- DECODE: `alu_src_a`=01, `alu_src_b`=01. This precomputes the branch/jump target.
  - Next state by opcode:
    - 0000011 / 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 0000000 → FETCH (no-op)
    - anything else → ILLEGAL
- MEMADR: `alu_src_a`=10, `alu_src_b`=01. Next MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: `adr_src`=1. Stay until `mem_ready`, then MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1. Next FETCH.
- MEMWRITE: `adr_src`=1, `mem_write`=1. `mem_write` stays high until `mem_ready`, then FETCH.
- EXECR: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10. Next ALUWB.
- EXECI: `alu_src_a`=10, `alu_src_b`=01, `alu_op`=10. Next ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1. Next FETCH.
- BRANCH: `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00.
  - `pc_write` = `zero` XOR `funct3[0]`.
  - Only funct3 000 (beq) and 001 (bne) are legal. Any other funct3 goes to ILLEGAL from DECODE, with no PC write.
  - Next FETCH.
- JAL: `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00, `result_src`=00, `pc_write`=1. Next ALUWB, which writes PC+4 to rd.
- ILLEGAL: all enables 0, `illegal`=1. The FSM stays here until `rst`.
- `imm_src` is decoded combinationally from `opcode` in every state: I for lw/op-imm, S for sw, B for branch, J for jal, 00 otherwise.

## Timing
- Reset: state ← FETCH on the first edge with `rst`=1.
  - While `rst`=1, `pc_write`, `ir_write`, `mem_write` and `reg_write` are forced to 0, and `illegal` is 0.
  - `rst` mid-instruction aborts it; nothing is written after the reset edge.
- All outputs are combinational from state, plus `mem_ready` (FETCH) and `zero` (BRANCH). No output is registered except `illegal`.
- Latency with zero wait states:
  - R-type, I-type, sw, jal: 4 cycles.
  - lw: 5 cycles.
  - branch: 3 cycles.
  - no-op: 2 cycles.
  - Each cycle of `mem_ready`=0 in a memory state adds 1 cycle.
- `mem_ready` is sampled at the rising edge. A `mem_ready` asserted outside a memory state is ignored.
- Writes happen at the edge that ends a write-enabled cycle, never earlier.

## Structure
- Package `rv_ctrl_pkg` holds:
  - the state enum (12 states, binary, 4 bits);
  - opcode localparams;
  - `result_src`, `alu_src_a`, `alu_src_b` and `imm_src` select constants.
- Sub-module: the existing `alu_ctrl`, instantiated unchanged and fed `alu_op`, `funct3`, `funct7` and `opcode[5]`.
- Two always blocks: a sequential state/`illegal` register and a combinational next-state/output decoder.

## Test plan
- add x3,x1,x2 (opcode 0110011), `mem_ready`=1 → states FETCH, DECODE, EXECR, ALUWB. `reg_write`=1 only in cycle 4; `alu_control` equals add.
- lw (0000011) with `mem_ready` low for 2 cycles in MEMREAD → 7 cycles total. `adr_src`=1 for 3 cycles; `reg_write` with `result_src`=01 in the final cycle.
- beq (funct3 000) with `zero`=1 → `pc_write`=1 in BRANCH. Same instruction with bne (funct3 001) → `pc_write`=0. funct3 010 → ILLEGAL.
- jal (1101111), `HAS_JAL`=1 → `pc_write`=1 in JAL, `reg_write`=1 in ALUWB. With `HAS_JAL`=0 → `illegal`=1 and it stays 1.
- Opcode 1111111 → ILLEGAL, all enables 0 for 10 cycles. Assert `rst` → `illegal`=0 and state FETCH on the next edge.
- sw (0100011) with `rst` asserted in MEMWRITE → `mem_write` drops in the reset cycle; FSM in FETCH after the edge.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: FSM state
// encoding, opcode values, datapath mux select constants, ALU operation
// codes and the immediate-format decode helper.
package rv_ctrl_pkg;

  // 12 states, binary encoded in 4 bits.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  // Opcodes (IR[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_NOP    = 7'b0000000;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  // result_src
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // alu_src_a
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  // alu_src_b
  localparam logic [1:0] SRCB_WDATA = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // imm_src
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // alu_op handed to alu_ctrl
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // alu_control codes
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  function automatic logic [1:0] imm_src_for(input logic [6:0] opcode);
    logic [1:0] imm;
    case (opcode)
      OP_LOAD, OP_OPIMM: imm = IMM_I;
      OP_STORE:          imm = IMM_S;
      OP_BRANCH:         imm = IMM_B;
      OP_JAL:            imm = IMM_J;
      default:           imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/alu_ctrl.sv
// ALU operation decoder shared with the single-cycle control unit.
// Ports:
//   alu_op      in  2 : 00 = add, 01 = subtract, 10 = decode funct3/funct7
//   funct3      in  3 : IR[14:12]
//   funct7      in  7 : IR[31:25]
//   op5         in  1 : opcode[5]; distinguishes R-type sub from I-type addi
//   alu_control out 4 : ALU operation code
module alu_ctrl
  import rv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       op5,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  alu_control = (op5 && funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for the multi-cycle RV32I datapath. Sequences each
// instruction through FETCH/DECODE and per-class execute states, stalls
// memory states on mem_ready, and locks into ILLEGAL on an undecodable
// instruction until reset.
// Ports:
//   clk, rst           : rising-edge clock, synchronous active-high reset
//   opcode/funct3/funct7: instruction register fields
//   zero               : ALU zero flag (branch decision)
//   mem_ready          : memory access completes this cycle
//   pc_write, ir_write, mem_write, reg_write : datapath enables
//   adr_src, result_src, alu_src_a, alu_src_b, imm_src : mux selects
//   alu_control        : ALU operation from alu_ctrl
//   illegal            : sticky illegal-instruction flag
module multicycle_control_fsm
  import rv_ctrl_pkg::*;
#(
  parameter bit WAIT_MEM = 1'b1,
  parameter bit HAS_JAL  = 1'b1,
  parameter bit HAS_BNE  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [3:0] alu_control,
  output logic       illegal
);

  state_t     state;
  state_t     state_next;
  logic       illegal_q;
  logic [1:0] alu_op;
  logic       mem_rdy;

  assign mem_rdy = WAIT_MEM ? mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next == S_ILLEGAL) begin
        illegal_q <= 1'b1;
      end
    end
  end

  // Masked during reset so the flag reads 0 as soon as rst is raised.
  assign illegal = illegal_q & ~rst;

  always_comb begin
    state_next = state;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_WDATA;
    alu_op     = ALUOP_ADD;
    imm_src    = imm_src_for(opcode);

    case (state)
      S_FETCH: begin
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        if (mem_rdy) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // OldPC + imm: branch/jump target precomputed into ALUOut.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_OP:             state_next = S_EXECR;
          OP_OPIMM:          state_next = S_EXECI;
          OP_BRANCH: begin
            if (funct3 == F3_BEQ || (HAS_BNE && funct3 == F3_BNE)) begin
              state_next = S_BRANCH;
            end else begin
              state_next = S_ILLEGAL;
            end
          end
          OP_JAL:            state_next = HAS_JAL ? S_JAL : S_ILLEGAL;
          OP_NOP:            state_next = S_FETCH;
          default:           state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = SRCA_REG;
        alu_src_b  = SRCB_IMM;
        state_next = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_rdy) begin
          state_next = S_MEMWB;
        end
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_rdy) begin
          state_next = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_a  = SRCA_REG;
        alu_src_b  = SRCB_WDATA;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a  = SRCA_REG;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_REG;
        alu_src_b  = SRCB_WDATA;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        // funct3[0] inverts the condition: beq takes on zero, bne on !zero.
        pc_write   = zero ^ funct3[0];
        state_next = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        state_next = S_ALUWB;
      end
      S_ILLEGAL: begin
        state_next = S_ILLEGAL;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase

    // Reset aborts the instruction in flight: no write may land on the
    // reset edge, whatever state the decoder is in.
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  alu_ctrl u_alu_ctrl (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7      (funct7),
    .op5         (opcode[5]),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Table-driven bench for multicycle_control_fsm. Each row gives the inputs
// for one clock cycle plus the state the FSM is expected to be in; the
// expected output vector for that state is pushed to a scoreboard when the
// row is driven and compared on the following falling edge.
module tb_multicycle_control_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst_nj;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero, mem_ready;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [3:0] alu_control;
    logic       illegal;
  } outs_t;

  typedef enum int {
    T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
    T_EXECR, T_EXECI, T_ALUWB, T_BRANCH, T_JAL, T_ILLEGAL
  } tstate_t;

  typedef struct {
    bit         sel;    // 0: default DUT, 1: HAS_JAL=0/HAS_BNE=0 DUT
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       zero;
    logic       mr;
    tstate_t    st;
  } vec_t;

  typedef struct {
    int      idx;
    bit      sel;
    tstate_t st;
    outs_t   exp;
  } sb_t;

  // default-parameter DUT
  logic       pw_m, as_m, mw_m, iw_m, rw_m, il_m;
  logic [1:0] rs_m, sa_m, sb_m, is_m;
  logic [3:0] ac_m;
  // reduced-ISA DUT
  logic       pw_n, as_n, mw_n, iw_n, rw_n, il_n;
  logic [1:0] rs_n, sa_n, sb_n, is_n;
  logic [3:0] ac_n;

  outs_t act_m, act_n;
  assign act_m = {pw_m, as_m, mw_m, iw_m, rw_m, rs_m, sa_m, sb_m, is_m, ac_m, il_m};
  assign act_n = {pw_n, as_n, mw_n, iw_n, rw_n, rs_n, sa_n, sb_n, is_n, ac_n, il_n};

  multicycle_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(mem_ready),
    .pc_write(pw_m), .adr_src(as_m), .mem_write(mw_m), .ir_write(iw_m),
    .reg_write(rw_m), .result_src(rs_m), .alu_src_a(sa_m), .alu_src_b(sb_m),
    .imm_src(is_m), .alu_control(ac_m), .illegal(il_m)
  );

  multicycle_control_fsm #(.WAIT_MEM(1'b1), .HAS_JAL(1'b0), .HAS_BNE(1'b0)) dut_nj (
    .clk(clk), .rst(rst_nj), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(mem_ready),
    .pc_write(pw_n), .adr_src(as_n), .mem_write(mw_n), .ir_write(iw_n),
    .reg_write(rw_n), .result_src(rs_n), .alu_src_a(sa_n), .alu_src_b(sb_n),
    .imm_src(is_n), .alu_control(ac_n), .illegal(il_n)
  );

  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] I   = 7'b0010011;
  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] NOP = 7'b0000000;
  localparam logic [6:0] BAD = 7'b1111111;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[$];
  sb_t  sb[$];

  // Current instruction used by row() when building the table.
  bit         ir_sel;
  logic [6:0] ir_opc;
  logic [2:0] ir_f3;
  logic [6:0] ir_f7;

  function void ir(bit sel, logic [6:0] opc, logic [2:0] f3, logic [6:0] f7);
    ir_sel = sel; ir_opc = opc; ir_f3 = f3; ir_f7 = f7;
  endfunction

  function void row(tstate_t st, logic z, logic mr, logic r);
    vec_t v;
    v.sel = ir_sel; v.rst = r; v.opcode = ir_opc; v.f3 = ir_f3; v.f7 = ir_f7;
    v.zero = z; v.mr = mr; v.st = st;
    vecs.push_back(v);
  endfunction

  // ALU codes: add 0, sub 1, and 2, or 3, xor 4, slt 5, sltu 6, sll 7, srl 8, sra 9
  function automatic logic [3:0] exp_alu(logic [1:0] aop, vec_t v);
    if (aop == 2'b00) return 4'd0;
    if (aop == 2'b01) return 4'd1;
    case (v.f3)
      3'b000:  return (v.opcode[5] && v.f7 == 7'b0100000) ? 4'd1 : 4'd0;
      3'b001:  return 4'd7;
      3'b010:  return 4'd5;
      3'b011:  return 4'd6;
      3'b100:  return 4'd4;
      3'b101:  return (v.f7 == 7'b0100000) ? 4'd9 : 4'd8;
      3'b110:  return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic outs_t exp_outs(vec_t v);
    outs_t      o;
    logic [1:0] aop;
    o   = '0;
    aop = 2'b00;
    case (v.opcode)
      LW, I:   o.imm_src = 2'b00;
      SW:      o.imm_src = 2'b01;
      BR:      o.imm_src = 2'b10;
      JL:      o.imm_src = 2'b11;
      default: o.imm_src = 2'b00;
    endcase
    case (v.st)
      T_FETCH:    begin o.result_src = 2'b10; o.alu_src_b = 2'b10;
                        o.ir_write = v.mr; o.pc_write = v.mr; end
      T_DECODE:   begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b01; end
      T_MEMADR:   begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; end
      T_MEMREAD:  o.adr_src = 1'b1;
      T_MEMWB:    begin o.result_src = 2'b01; o.reg_write = 1'b1; end
      T_MEMWRITE: begin o.adr_src = 1'b1; o.mem_write = 1'b1; end
      T_EXECR:    begin o.alu_src_a = 2'b10; aop = 2'b10; end
      T_EXECI:    begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; aop = 2'b10; end
      T_ALUWB:    o.reg_write = 1'b1;
      T_BRANCH:   begin o.alu_src_a = 2'b10; aop = 2'b01; o.pc_write = v.zero ^ v.f3[0]; end
      T_JAL:      begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; o.pc_write = 1'b1; end
      default:    o.illegal = 1'b1;
    endcase
    o.alu_control = exp_alu(aop, v);
    if (v.rst) begin
      o.pc_write = 1'b0; o.ir_write = 1'b0; o.mem_write = 1'b0;
      o.reg_write = 1'b0; o.illegal = 1'b0;
    end
    return o;
  endfunction

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      sb_t   e;
      outs_t act;
      e   = sb.pop_front();
      act = e.sel ? act_n : act_m;
      n_checks++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL row%0d dut%0d %s: got %h expected %h", e.idx, e.sel, e.st.name(), act, e.exp);
      end
    end
  end

  initial begin
    // add x3,x1,x2 with mem_ready noise outside memory states
    ir(0, R, 3'b000, 7'b0000000);
    row(T_FETCH, 0, 1, 0); row(T_DECODE, 0, 0, 0); row(T_EXECR, 0, 1, 0); row(T_ALUWB, 0, 0, 0);
    // sub with a one-cycle fetch stall
    ir(0, R, 3'b000, 7'b0100000);
    row(T_FETCH, 0, 0, 0); row(T_FETCH, 0, 1, 0); row(T_DECODE, 0, 1, 0);
    row(T_EXECR, 0, 1, 0); row(T_ALUWB, 0, 1, 0);
    // lw, two wait states in MEMREAD: 7 cycles
    ir(0, LW, 3'b010, 7'b0000000);
    row(T_FETCH, 0, 1, 0); row(T_DECODE, 0, 1, 0); row(T_MEMADR, 0, 0, 0);
    row(T_MEMREAD, 0, 0, 0); row(T_MEMREAD, 0, 0, 0); row(T_MEMREAD, 0, 1, 0); row(T_MEMWB, 0, 0, 0);
    // andi
    ir(0, I, 3'b111, 7'b0000000);
    row(T_FETCH, 0, 1, 0); row(T_DECODE, 0, 1, 0); row(T_EXECI, 0, 1, 0); row(T_ALUWB, 0, 1, 0);
    // beq/bne with zero high and low
    ir(0, BR, 3'b000, 7'b0000000);
    row(T_FETCH, 0, 1, 0); row(T_DECODE, 1, 1, 0); row(T_BRANCH, 1, 1, 0);
    ir(0, BR, 3'b001, 7'b0000000);
    row(T_FETCH, 1, 1, 0); row(T_DECODE, 1, 1, 0); row(T_BRANCH, 1, 1, 0);
    row(T_FETCH, 0, 1, 0); row(T_DECODE, 0, 1, 0); row(T_BRANCH, 0, 1, 0);
    ir(0, BR, 3'b000, 7'b0000000);
    row(T_FETCH, 0, 1, 0); row(T_DECODE, 0, 1, 0); row(T_BRANCH, 0, 1, 0);
    // jal
    ir(0, JL, 3'b000, 7'b0000000);
    row(T_FETCH, 0, 1, 0); row(T_DECODE, 0, 1, 0); row(T_JAL, 0, 1, 0); row(T_ALUWB, 0, 1, 0);
    // no-op: 2 cycles
    ir(0, NOP, 3'b000, 7'b0000000);
    row(T_FETCH, 0, 1, 0); row(T_DECODE, 0, 1, 0);
    // sw with one wait state
    ir(0, SW, 3'b010, 7'b0000000);
    row(T_FETCH, 0, 1, 0); row(T_DECODE, 0, 1, 0); row(T_MEMADR, 0, 1, 0);
    row(T_MEMWRITE, 0, 0, 0); row(T_MEMWRITE, 0, 1, 0);
    // sw aborted by reset in MEMWRITE
    row(T_FETCH, 0, 1, 0); row(T_DECODE, 0, 1, 0); row(T_MEMADR, 0, 1, 0);
    row(T_MEMWRITE, 0, 0, 0); row(T_MEMWRITE, 0, 0, 1);
    // lw aborted by reset in MEMWB
    ir(0, LW, 3'b010, 7'b0000000);
    row(T_FETCH, 0, 1, 0); row(T_DECODE, 0, 1, 0); row(T_MEMADR, 0, 1, 0);
    row(T_MEMREAD, 0, 1, 0); row(T_MEMWB, 0, 1, 1);
    // reset during a ready FETCH: no IR/PC write, stays in FETCH
    ir(0, R, 3'b100, 7'b0000000);
    row(T_FETCH, 0, 1, 1);
    // xor
    row(T_FETCH, 0, 1, 0); row(T_DECODE, 0, 1, 0); row(T_EXECR, 0, 1, 0); row(T_ALUWB, 0, 1, 0);
    // branch funct3 010 is illegal; reset recovers
    ir(0, BR, 3'b010, 7'b0000000);
    row(T_FETCH, 1, 1, 0); row(T_DECODE, 1, 1, 0); row(T_ILLEGAL, 1, 1, 0);
    row(T_ILLEGAL, 0, 0, 0); row(T_ILLEGAL, 0, 1, 1);
    // undefined opcode: locked for 10 cycles, then reset
    ir(0, BAD, 3'b000, 7'b0000000);
    row(T_FETCH, 0, 1, 0); row(T_DECODE, 0, 1, 0);
    for (int unsigned k = 0; k < 10; k++) row(T_ILLEGAL, k[0], k[1], 0);
    row(T_ILLEGAL, 0, 1, 1);
    ir(0, R, 3'b000, 7'b0000000);
    row(T_FETCH, 0, 1, 0); row(T_DECODE, 0, 1, 0); row(T_EXECR, 0, 1, 0); row(T_ALUWB, 0, 1, 0);
    // reduced-ISA DUT: jal and bne are illegal, beq still works
    ir(1, JL, 3'b000, 7'b0000000);
    row(T_FETCH, 0, 1, 0); row(T_DECODE, 0, 1, 0);
    for (int unsigned k = 0; k < 4; k++) row(T_ILLEGAL, 0, k[0], 0);
    row(T_ILLEGAL, 0, 1, 1);
    ir(1, BR, 3'b000, 7'b0000000);
    row(T_FETCH, 1, 1, 0); row(T_DECODE, 1, 1, 0); row(T_BRANCH, 1, 1, 0);
    ir(1, BR, 3'b001, 7'b0000000);
    row(T_FETCH, 0, 1, 0); row(T_DECODE, 0, 1, 0); row(T_ILLEGAL, 0, 1, 0); row(T_ILLEGAL, 0, 1, 0);

    // Hold both DUTs in reset, then release into the table.
    rst = 1'b1; rst_nj = 1'b1; opcode = NOP; funct3 = '0; funct7 = '0;
    zero = 1'b0; mem_ready = 1'b0;
    repeat (3) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      sb_t e;
      @(posedge clk);
      #1;
      if (vecs[i].sel) begin
        rst = 1'b1; rst_nj = vecs[i].rst;
      end else begin
        rst = vecs[i].rst; rst_nj = 1'b1;
      end
      opcode = vecs[i].opcode; funct3 = vecs[i].f3; funct7 = vecs[i].f7;
      zero = vecs[i].zero; mem_ready = vecs[i].mr;
      e.idx = i; e.sel = vecs[i].sel; e.st = vecs[i].st; e.exp = exp_outs(vecs[i]);
      sb.push_back(e);
    end

    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
